sccb_reg_sequencer: RTL and testbench

SCCB_REG_SEQUENCER -- requirements
Module: sccb_reg_sequencer

---
 rtl/sccb_reg_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sccb_reg_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sccb_reg_sequencer
// Purpose  : Walks a register table and writes each entry to an SCCB camera
//            through a byte controller (device address, register, value).
//            Supports millisecond delay entries, NACK retries with abort
//            stop, and a sticky error flag with the last failing index.
// Revision : 1.0 - initial release
// ============================================================================
module sccb_reg_sequencer #(
  parameter logic [7:0]  DEV_ADDR   = 8'h42,
  parameter logic [15:0] CLK_PER_MS = 16'd50000,
  parameter logic [1:0]  MAX_RETRY  = 2'd3,
  parameter int          TBL_AW     = 8
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              go,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              bc_start,
  output logic              bc_stop,
  output logic              bc_write,
  output logic              bc_read,
  output logic [7:0]        bc_din,
  input  logic              bc_ack,
  input  logic              bc_ack_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [TBL_AW-1:0] err_addr
);

  localparam logic [15:0] C_TERM_ENTRY = 16'hFFFF;
  localparam logic [7:0]  C_DELAY_REG  = 8'hFE;
  localparam logic [15:0] C_MS_LAST    = CLK_PER_MS - 16'd1;
  localparam logic [TBL_AW-1:0] C_ADDR_ONE = {{(TBL_AW-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_DEV    = 4'd3,
    S_REG    = 4'd4,
    S_DATA   = 4'd5,
    S_ABORT  = 4'd6,
    S_DELAY  = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  state_t              state_q, state_d;
  logic [TBL_AW-1:0]   tbl_addr_q, tbl_addr_d;
  logic [1:0]          retry_q, retry_d;
  logic [15:0]         entry_q, entry_d;
  logic                start_q, start_d;
  logic                stop_q, stop_d;
  logic                write_q, write_d;
  logic [7:0]          din_q, din_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [TBL_AW-1:0]   err_addr_q, err_addr_d;
  logic [15:0]         ms_cnt_q, ms_cnt_d;
  logic [7:0]          ms_left_q, ms_left_d;

  // A command is outstanding while any command bit is held; every command
  // carries either write or stop.
  logic w_issued;
  logic w_advance;
  logic w_retry;

  assign w_issued = write_q | stop_q;

  // State and datapath registers; reset never emits a stop on the bus.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q    <= S_IDLE;
      tbl_addr_q <= '0;
      retry_q    <= '0;
      entry_q    <= '0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      write_q    <= 1'b0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      ms_cnt_q   <= '0;
      ms_left_q  <= '0;
    end else begin
      state_q    <= state_d;
      tbl_addr_q <= tbl_addr_d;
      retry_q    <= retry_d;
      entry_q    <= entry_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      write_q    <= write_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      ms_cnt_q   <= ms_cnt_d;
      ms_left_q  <= ms_left_d;
    end
  end

  // Next-state logic: per-state actions, then shared retry and advance paths.
  always_comb begin
    state_d    = state_q;
    tbl_addr_d = tbl_addr_q;
    retry_d    = retry_q;
    entry_d    = entry_q;
    start_d    = start_q;
    stop_d     = stop_q;
    write_d    = write_q;
    din_d      = din_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    ms_cnt_d   = ms_cnt_q;
    ms_left_d  = ms_left_q;
    w_advance  = 1'b0;
    w_retry    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          tbl_addr_d = '0;
          retry_d    = '0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_FETCH;
        end
      end

      // Table read latency: data is valid one cycle after the address moves.
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        entry_d = tbl_data;
        if (tbl_data == C_TERM_ENTRY) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (tbl_data[15:8] == C_DELAY_REG) begin
          if (tbl_data[7:0] == 8'd0) begin
            w_advance = 1'b1;
          end else begin
            ms_cnt_d  = '0;
            ms_left_d = tbl_data[7:0];
            state_d   = S_DELAY;
          end
        end else begin
          state_d = S_DEV;
        end
      end

      // Each command state raises its bits once after entry and drops them
      // on the cycle following bc_ack, which guarantees an idle gap.
      S_DEV: begin
        if (!w_issued) begin
          start_d = 1'b1;
          write_d = 1'b1;
          din_d   = DEV_ADDR;
        end else if (bc_ack) begin
          start_d = 1'b0;
          write_d = 1'b0;
          state_d = bc_ack_out ? S_ABORT : S_REG;
        end
      end

      S_REG: begin
        if (!w_issued) begin
          write_d = 1'b1;
          din_d   = entry_q[15:8];
        end else if (bc_ack) begin
          write_d = 1'b0;
          state_d = bc_ack_out ? S_ABORT : S_DATA;
        end
      end

      // The data byte already carries the stop, so a NACK goes straight to
      // the retry decision.
      S_DATA: begin
        if (!w_issued) begin
          write_d = 1'b1;
          stop_d  = 1'b1;
          din_d   = entry_q[7:0];
        end else if (bc_ack) begin
          write_d = 1'b0;
          stop_d  = 1'b0;
          if (bc_ack_out) begin
            w_retry = 1'b1;
          end else begin
            w_advance = 1'b1;
          end
        end
      end

      S_ABORT: begin
        if (!w_issued) begin
          stop_d = 1'b1;
        end else if (bc_ack) begin
          stop_d  = 1'b0;
          w_retry = 1'b1;
        end
      end

      // Nested counters: cycles within a millisecond, then milliseconds left.
      S_DELAY: begin
        if (ms_cnt_q == C_MS_LAST) begin
          ms_cnt_d = '0;
          if (ms_left_q == 8'd1) begin
            ms_left_d = '0;
            w_advance = 1'b1;
          end else begin
            ms_left_d = ms_left_q - 8'd1;
          end
        end else begin
          ms_cnt_d = ms_cnt_q + 16'd1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (w_retry) begin
      if (retry_q < MAX_RETRY) begin
        retry_d = retry_q + 2'd1;
        state_d = S_FETCH;
      end else begin
        err_d      = 1'b1;
        err_addr_d = tbl_addr_q;
        w_advance  = 1'b1;
      end
    end

    // The last table slot ends the run instead of wrapping to entry 0.
    if (w_advance) begin
      retry_d = '0;
      if (&tbl_addr_q) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        tbl_addr_d = tbl_addr_q + C_ADDR_ONE;
        state_d    = S_FETCH;
      end
    end
  end

  assign tbl_addr = tbl_addr_q;
  assign bc_start = start_q;
  assign bc_stop  = stop_q;
  assign bc_write = write_q;
  assign bc_read  = 1'b0;
  assign bc_din   = din_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_sccb_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sccb_reg_sequencer
// Purpose  : Self-checking bench: table memory, responding byte controller
//            with programmable NACKs, and an entry-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sccb_reg_sequencer;

  localparam logic [7:0]  DEV   = 8'h42;
  localparam logic [15:0] CPM   = 16'd10;
  localparam logic [1:0]  MR    = 2'd3;
  localparam int          LIMIT = 4000;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_data = 16'h0;
  logic        bc_start, bc_stop, bc_write, bc_read;
  logic [7:0]  bc_din;
  logic        bc_ack = 1'b0;
  logic        bc_ack_out = 1'b0;
  logic        busy, done, err;
  logic [7:0]  err_addr;

  sccb_reg_sequencer #(
    .DEV_ADDR(DEV), .CLK_PER_MS(CPM), .MAX_RETRY(MR), .TBL_AW(8)
  ) dut (
    .clk(clk), .nReset(nReset), .go(go), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .bc_start(bc_start), .bc_stop(bc_stop),
    .bc_write(bc_write), .bc_read(bc_read), .bc_din(bc_din),
    .bc_ack(bc_ack), .bc_ack_out(bc_ack_out), .busy(busy), .done(done),
    .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Synchronous table memory.
  logic [15:0] tbl [256];
  always @(posedge clk) tbl_data <= tbl[tbl_addr];

  typedef struct packed {
    logic       s;
    logic       p;
    logic       w;
    logic [7:0] din;
  } cmd_t;

  cmd_t got_q[$];
  cmd_t exp_q[$];
  bit   exp_care_q[$];

  int vectors = 0;
  int miscompares = 0;
  int gap_viol = 0;
  int cap_ord = 0;
  int m_ord = 0;
  int exp_err, exp_err_addr, exp_last;
  bit nack_arr [1024];
  bit nack_dev_all = 1'b0;

  function automatic bit nack_of(input int ord, input bit is_start);
    return nack_arr[ord % 1024] | (nack_dev_all & is_start);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte controller: captures a command, acks after a random latency, and
  // checks that command bits are low in the cycle after each ack.
  int bcm_cnt = 0;
  bit bcm_act = 1'b0;
  bit bcm_nack = 1'b0;
  always @(negedge clk) begin
    if (bc_read !== 1'b0) gap_viol++;
    if (!nReset) begin
      bc_ack = 1'b0;
      bc_ack_out = 1'b0;
      bcm_act = 1'b0;
    end else if (bc_ack) begin
      bc_ack = 1'b0;
      bc_ack_out = 1'b0;
      if (bc_start | bc_stop | bc_write) gap_viol++;
    end else if (!bcm_act) begin
      if (bc_start | bc_stop | bc_write) begin
        got_q.push_back('{bc_start, bc_stop, bc_write, bc_din});
        bcm_nack = nack_of(cap_ord, bc_start);
        cap_ord++;
        bcm_act = 1'b1;
        bcm_cnt = $urandom_range(0, 3);
      end
    end else if (bcm_cnt == 0) begin
      bc_ack = 1'b1;
      bc_ack_out = bcm_nack;
      bcm_act = 1'b0;
    end else begin
      bcm_cnt--;
    end
  end

  function automatic bit model_cmd(input bit s, input bit p, input bit w,
                                   input logic [7:0] d, input bit care);
    exp_q.push_back('{s, p, w, d});
    exp_care_q.push_back(care);
    model_cmd = nack_of(m_ord, s);
    m_ord++;
  endfunction

  // Reference: expected command list and final flags, entry by entry.
  task automatic build_expected();
    int idx;
    int attempt;
    bit fail;
    logic [15:0] e;
    exp_q.delete();
    exp_care_q.delete();
    exp_err = 0;
    exp_err_addr = 0;
    idx = 0;
    forever begin
      e = tbl[idx];
      if (e == 16'hFFFF) break;
      if (e[15:8] != 8'hFE) begin
        attempt = 0;
        forever begin
          if (model_cmd(1, 0, 1, DEV, 1)) begin
            void'(model_cmd(0, 1, 0, 8'h00, 0));
            fail = 1;
          end else if (model_cmd(0, 0, 1, e[15:8], 1)) begin
            void'(model_cmd(0, 1, 0, 8'h00, 0));
            fail = 1;
          end else begin
            fail = model_cmd(0, 1, 1, e[7:0], 1);
          end
          if (!fail) break;
          if (attempt == int'(MR)) begin
            exp_err = 1;
            exp_err_addr = idx;
            break;
          end
          attempt++;
        end
      end
      if (idx == 255) break;
      idx++;
    end
    exp_last = idx;
  endtask

  task automatic run(input string name, input bit extra_go, output int cycles);
    int n;
    got_q.delete();
    cap_ord = 0;
    m_ord = 0;
    build_expected();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk({name, "_busy"}, busy, 1);
    n = 1;
    while (done !== 1'b1 && n < LIMIT) begin
      go = extra_go && ($urandom_range(0, 5) == 0);
      @(negedge clk);
      n++;
    end
    go = 1'b0;
    cycles = n;
    chk({name, "_done"}, done, 1);
    chk({name, "_busy_end"}, busy, 0);
    chk({name, "_err"}, err, exp_err);
    chk({name, "_err_addr"}, err_addr, exp_err_addr);
    chk({name, "_tbl_addr"}, tbl_addr, exp_last);
    @(negedge clk);
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_ncmds"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_cmd%0d_ctl", name, i),
          {got_q[i].s, got_q[i].p, got_q[i].w}, {exp_q[i].s, exp_q[i].p, exp_q[i].w});
      if (exp_care_q[i]) chk($sformatf("%s_cmd%0d_din", name, i), got_q[i].din, exp_q[i].din);
    end
  endtask

  initial begin
    int c0, c1, k, n, len;
    logic [7:0] rg;
    for (int i = 0; i < 256; i++) tbl[i] = 16'hFFFF;
    for (int i = 0; i < 1024; i++) nack_arr[i] = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_state", {bc_start, bc_stop, bc_write, bc_read, busy, done, err,
                        bc_din, tbl_addr, err_addr}, 0);
    nReset = 1'b1;
    @(negedge clk);

    // Single write, all ACK.
    tbl[0] = 16'h1280;
    run("basic", 0, c0);
    chk("basic_last_din", got_q[got_q.size()-1].din, 8'h80);

    // One NACK on the register byte of the first attempt.
    nack_arr[1] = 1'b1;
    run("reg_nack", 0, c0);
    nack_arr[1] = 1'b0;
    chk("reg_nack_ncmd", got_q.size(), 6);

    // Every device byte NACKed: four attempts then the error flag.
    nack_dev_all = 1'b1;
    run("dev_nack", 0, c0);
    nack_dev_all = 1'b0;
    chk("dev_nack_ncmd", got_q.size(), 8);

    // Delay entries: run length difference equals value * CLK_PER_MS.
    tbl[0] = 16'hFE00;
    run("delay0", 0, c0);
    tbl[0] = 16'hFE02;
    run("delay2", 0, c1);
    chk("delay2_cycles", c1 - c0, 20);
    k = $urandom_range(1, 5);
    tbl[0] = {8'hFE, 8'(k)};
    run("delayk", 0, c1);
    chk("delayk_cycles", c1 - c0, k * int'(CPM));

    // Random tables with random NACKs and stray go pulses while busy.
    repeat (3) begin
      for (int i = 0; i < 256; i++) tbl[i] = 16'hFFFF;
      for (int i = 0; i < 1024; i++) nack_arr[i] = ($urandom_range(0, 3) == 0);
      len = $urandom_range(2, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          tbl[i] = {8'hFE, 8'($urandom_range(0, 2))};
        end else begin
          rg = 8'($urandom);
          if (rg == 8'hFE) rg = 8'h11;
          tbl[i] = {rg, 8'($urandom)};
          if (tbl[i] == 16'hFFFF) tbl[i] = 16'hFF00;
        end
      end
      run("rand", 1, c0);
    end
    for (int i = 0; i < 1024; i++) nack_arr[i] = 1'b0;

    // Last table slot holds a real write: run must end there without wrap.
    for (int i = 0; i < 255; i++) tbl[i] = 16'hFE00;
    tbl[255] = {8'($urandom_range(0, 8'hFD)), 8'($urandom)};
    run("wrap", 0, c0);
    for (int i = 0; i < 256; i++) tbl[i] = 16'hFFFF;

    // Reset while the data byte is on the bus, then restart.
    tbl[0] = 16'h1280;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (!(bc_write === 1'b1 && bc_stop === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("data_phase_seen", {bc_write, bc_stop}, 2'b11);
    nReset = 1'b0;
    @(negedge clk);
    chk("reset_mid", {bc_start, bc_stop, bc_write, bc_read, busy, done, err,
                      bc_din, tbl_addr, err_addr}, 0);
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    run("restart", 0, c0);

    chk("cmd_gap_and_read", gap_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
